key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes raw pushbuttons and slide switches, then
// debounces each pushbutton with its own FSM. The result is a level, a press
// pulse and a release pulse per key, plus an OR of all press pulses.

// One key: an active-high "pressed" input (already synchronized) drives a
// four-state debouncer. All outputs are registered. press_nxt is the
// combinational next value of press_o, so the top can register the OR of
// all keys on the same edge.
module key_lane #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pressed,
   output logic level_o,
   output logic press_o,
   output logic rel_o,
   output logic press_nxt
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_UP        = 2'd0,
      ST_WAIT_DOWN = 2'd1,
      ST_DOWN      = 2'd2,
      ST_WAIT_UP   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            rel_q, rel_d;

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UP;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   // Next state; the counter is cleared on every entry to a WAIT state and
   // holds at the terminal count, so it can never wrap. Pulses fire only
   // on completed WAIT transitions, not on bounce returns.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         ST_UP: begin
            if (pressed) begin
               state_d = ST_WAIT_DOWN;
               cnt_d   = '0;
            end
         end
         ST_WAIT_DOWN: begin
            if (!pressed) begin
               state_d = ST_UP;
               cnt_d   = '0;
            end else if (cnt_q == TERM) begin
               state_d = ST_DOWN;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DOWN: begin
            if (!pressed) begin
               state_d = ST_WAIT_UP;
               cnt_d   = '0;
            end
         end
         ST_WAIT_UP: begin
            if (pressed) begin
               state_d = ST_DOWN;
               cnt_d   = '0;
            end else if (cnt_q == TERM) begin
               state_d = ST_UP;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_UP;
            cnt_d   = '0;
         end
      endcase
      level_d = (state_d == ST_DOWN) || (state_d == ST_WAIT_UP);
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign rel_o     = rel_q;
   assign press_nxt = press_d;

endmodule

module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int N_KEYS          = 4,
   parameter int N_SW            = 10
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic [N_KEYS-1:0] KEY,
   input  logic [N_SW-1:0]   SW,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_SW-1:0]   sw_sync,
   output logic              any_press
);

   logic [N_KEYS-1:0] key_meta_q, key_meta_d;
   logic [N_KEYS-1:0] key_sync_q, key_sync_d;
   logic [N_SW-1:0]   sw_meta_q, sw_meta_d;
   logic [N_SW-1:0]   sw_sync_q, sw_sync_d;
   logic              any_press_q, any_press_d;
   logic [N_KEYS-1:0] press_nxt;

   // Synchronizer next values: plain shift of the raw inputs
   always_comb begin
      key_meta_d = KEY;
      key_sync_d = key_meta_q;
      sw_meta_d  = SW;
      sw_sync_d  = sw_meta_q;
   end

   // Two-flop synchronizers; keys reset to released (1), switches to 0
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         key_meta_q <= '1;
         key_sync_q <= '1;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
      end else begin
         key_meta_q <= key_meta_d;
         key_sync_q <= key_sync_d;
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
      end
   end

   // One independent debouncer per key; KEY is active-low so invert here
   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_lane (
         .clk       (CLOCK_50),
         .rst_n     (Resetn),
         .pressed   (~key_sync_q[k]),
         .level_o   (key_level[k]),
         .press_o   (key_press[k]),
         .rel_o     (key_release[k]),
         .press_nxt (press_nxt[k])
      );
   end

   // any_press is formed from next-cycle press values so it lines up with key_press
   always_comb begin
      any_press_d = |press_nxt;
   end

   // any_press register
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) any_press_q <= 1'b0;
      else         any_press_q <= any_press_d;
   end

   assign sw_sync   = sw_sync_q;
   assign any_press = any_press_q;

endmodule
